// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the mini-MIPS multi-cycle sequencer: states, mux selects,
// multi-cycle ALU ops and the jr jump-source code.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } mc_state_e;

  localparam logic [SEL_W-1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] PC_SRC_REG    = 2'b11;

  localparam logic [SEL_W-1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [SEL_W-1:0] WB_SEL_LINK = 2'b10;
  localparam logic [SEL_W-1:0] WB_SEL_FP   = 2'b11;

  localparam logic [SEL_W-1:0] JSRC_JR = 2'b10;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

  localparam logic [ALUOP_W-1:0] ALU_OP_MULT = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_OP_DIV  = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_OP_DIVU = 4'b0101;

  // R-type ops that run on the iterative ALU and need the start/done handshake.
  function automatic logic is_multicycle(input logic [OP_W-1:0]    opcode,
                                         input logic [ALUOP_W-1:0] alu_op);
    return (opcode == OP_RTYPE) &&
           ((alu_op == ALU_OP_MULT) || (alu_op == ALU_OP_DIV) || (alu_op == ALU_OP_DIVU));
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Cycle and retired-instruction counters; only present when MC_PERF_CNT_EN is defined.
`ifdef MC_PERF_CNT_EN
module mc_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (en)     cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the mini-MIPS datapath.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 0,
  parameter int unsigned LINK_REG    = 31,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_is_float,
  input  logic             dec_mfc1,
  input  logic             dec_mtc1,
  input  logic [1:0]       dec_jump_src,
  input  logic [3:0]       dec_alu_op,
  input  logic [5:0]       dec_opcode,
  input  logic             branch_cond,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic             fp_rf_we,
  output logic             fcc_we,
  output logic [1:0]       wb_sel,
  output logic             link_we,
  output logic             alu_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned TMO_W   = 32;
  localparam logic [TMO_W-1:0] TIMEOUT = TMO_W'(ALU_TIMEOUT);
  // A link into $zero would be discarded by the register file, so jal skips the write.
  localparam bit LINK_OK = (LINK_REG != 0) && (LINK_REG < 32);

  mc_state_e        state_q, state_d;
  logic             alu_wait_q, alu_wait_d;
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             alu_err_q, alu_err_d;
  logic             exec_done;
  logic             mc_op;
  logic             is_jal;
  logic             timeout_hit;

  assign mc_op       = is_multicycle(dec_opcode, dec_alu_op);
  assign is_jal      = dec_jump && (dec_opcode == OP_JAL);
  assign timeout_hit = (TIMEOUT != '0) && ((wait_cnt_q + TMO_W'(1)) == TIMEOUT);

  assign state   = state_q;
  assign alu_err = alu_err_q;

  // State and ALU-wait bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      alu_wait_q <= 1'b0;
      wait_cnt_q <= '0;
      alu_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_wait_q <= alu_wait_d;
      wait_cnt_q <= wait_cnt_d;
      alu_err_q  <= alu_err_d;
    end
  end

  // Next state and control strobes; everything is forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    alu_wait_d = alu_wait_q;
    wait_cnt_d = wait_cnt_q;
    alu_err_d  = alu_err_q;
    exec_done  = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_start  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PC4;
    rf_we      = 1'b0;
    fp_rf_we   = 1'b0;
    fcc_we     = 1'b0;
    wb_sel     = WB_SEL_ALU;
    link_we    = 1'b0;

    if (rst_n) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req = en;
          if (en && imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_PC4;
            state_d  = ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (dec_jump) begin
            pc_write = 1'b1;
            pc_src   = (dec_jump_src == JSRC_JR) ? PC_SRC_REG : PC_SRC_JUMP;
            if (is_jal && LINK_OK) begin
              rf_we   = 1'b1;
              link_we = 1'b1;
              wb_sel  = WB_SEL_LINK;
            end
            state_d = ST_FETCH;
          end else begin
            state_d = ST_EXEC;
          end
        end

        ST_EXEC: begin
          // First EXEC cycle of a multi-cycle op only issues start; done is honoured afterwards.
          if (!mc_op) begin
            exec_done = 1'b1;
          end else if (!alu_wait_q) begin
            alu_start  = 1'b1;
            alu_wait_d = 1'b1;
            wait_cnt_d = '0;
          end else if (alu_done) begin
            exec_done = 1'b1;
          end else if (timeout_hit) begin
            exec_done = 1'b1;
            alu_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + TMO_W'(1);
          end

          if (exec_done) begin
            alu_wait_d = 1'b0;
            if (dec_branch) begin
              pc_write = branch_cond;
              pc_src   = PC_SRC_BRANCH;
              state_d  = ST_FETCH;
            end else if (dec_mem_read || dec_mem_write) begin
              state_d = ST_MEM;
            end else begin
              state_d = ST_WB;
            end
          end
        end

        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_mem_write;
          if (dmem_ready) state_d = dec_mem_read ? ST_WB : ST_FETCH;
        end

        ST_WB: begin
          rf_we    = (dec_reg_write && !dec_is_float) || dec_mfc1;
          fp_rf_we = (dec_reg_write && dec_is_float && !dec_mfc1) || dec_mtc1;
          fcc_we   = dec_is_float && !dec_reg_write && !dec_mtc1;
          if (dec_mem_read)  wb_sel = WB_SEL_MEM;
          else if (dec_mfc1) wb_sel = WB_SEL_FP;
          else               wb_sel = WB_SEL_ALU;
          state_d = ST_FETCH;
        end

        default: state_d = ST_FETCH;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic retire;

  // Final cycle of an instruction is any non-FETCH cycle heading back to FETCH.
  assign retire = rst_n && (state_q != ST_FETCH) && (state_d == ST_FETCH);

  mc_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written corner sequences.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;
  localparam int NV = 16;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, alu_done = 1'b0, branch_cond = 1'b0;
  logic dec_reg_write = 1'b0, dec_mem_read = 1'b0, dec_mem_write = 1'b0, dec_branch = 1'b0;
  logic dec_jump = 1'b0, dec_is_float = 1'b0, dec_mfc1 = 1'b0, dec_mtc1 = 1'b0;
  logic [1:0] dec_jump_src = 2'b00;
  logic [3:0] dec_alu_op = 4'b0000;
  logic [5:0] dec_opcode = 6'h00;

  logic imem_req, dmem_req, dmem_we, alu_start, ir_write, pc_write;
  logic rf_we, fp_rf_we, fcc_we, link_we, alu_err;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [17:0] outs;

  assign outs = {imem_req, dmem_req, dmem_we, alu_start, ir_write, pc_write, pc_src,
                 rf_we, fp_rf_we, fcc_we, wb_sel, link_we, alu_err, state};

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .ALU_TIMEOUT (4),
    .LINK_REG    (31),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en),
    .imem_req (imem_req), .imem_ready (imem_ready),
    .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_ready (dmem_ready),
    .dec_reg_write (dec_reg_write), .dec_mem_read (dec_mem_read),
    .dec_mem_write (dec_mem_write), .dec_branch (dec_branch), .dec_jump (dec_jump),
    .dec_is_float (dec_is_float), .dec_mfc1 (dec_mfc1), .dec_mtc1 (dec_mtc1),
    .dec_jump_src (dec_jump_src), .dec_alu_op (dec_alu_op), .dec_opcode (dec_opcode),
    .branch_cond (branch_cond), .alu_start (alu_start), .alu_done (alu_done),
    .ir_write (ir_write), .pc_write (pc_write), .pc_src (pc_src),
    .rf_we (rf_we), .fp_rf_we (fp_rf_we), .fcc_we (fcc_we), .wb_sel (wb_sel),
    .link_we (link_we), .alu_err (alu_err), .state (state),
    .cycle_cnt (cycle_cnt), .instret_cnt (instret_cnt)
  );

  typedef struct {
    logic [5:0] opcode;
    logic [3:0] alu_op;
    logic [8:0] flags;     // {reg_write, mem_read, mem_write, branch, jump, is_float, mfc1, mtc1, cond}
    logic [1:0] jsrc;
    int mem_delay;         // MEM cycles before dmem_ready
    int alu_lat;           // 0 = never done, -1 = done held high, n = done n cycles after start
    int e_cyc, e_pcw, e_src, e_rf, e_wb, e_fp, e_fcc, e_link, e_start, e_mem, e_we;
  } vec_t;

  typedef struct {
    int cyc, irw, pcw, src, rf, wb, fp, fcc, link, start, mem, we;
  } obs_t;

  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;
  int n_ret = 0;

  function automatic vec_t mk(input logic [5:0] op, input logic [3:0] aop, input logic [8:0] fl,
                              input logic [1:0] js, input int md, input int lat,
                              input int cyc, input int pcw, input int src, input int rf,
                              input int wb, input int fp, input int fcc, input int lnk,
                              input int st, input int mem, input int we);
    vec_t v;
    v.opcode = op; v.alu_op = aop; v.flags = fl; v.jsrc = js;
    v.mem_delay = md; v.alu_lat = lat;
    v.e_cyc = cyc; v.e_pcw = pcw; v.e_src = src; v.e_rf = rf; v.e_wb = wb; v.e_fp = fp;
    v.e_fcc = fcc; v.e_link = lnk; v.e_start = st; v.e_mem = mem; v.e_we = we;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Runs one instruction starting at a FETCH negedge; returns at the next FETCH negedge.
  task automatic run_instr(input vec_t v, input int drop_en, output obs_t o);
    int mem_n, exec_n, c;
    o = '{default: 0};
    {dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump,
     dec_is_float, dec_mfc1, dec_mtc1, branch_cond} = v.flags;
    dec_opcode = v.opcode; dec_alu_op = v.alu_op; dec_jump_src = v.jsrc;
    en = 1'b1;
    mem_n = 0; exec_n = 0; c = 0;
    while (c < MAXC && !(c > 0 && state == ST_FETCH)) begin
      if (c == drop_en) en = 1'b0;
      imem_ready = 1'b1;
      if (state == ST_MEM) mem_n++;
      if (state == ST_EXEC) exec_n++;
      dmem_ready = (state == ST_MEM) ? (mem_n > v.mem_delay) : 1'b1;
      alu_done = (state == ST_EXEC) && (v.alu_lat != 0) && (exec_n > v.alu_lat);
      #1;
      o.cyc++;
      if (ir_write) o.irw++;
      if (pc_write && state != ST_FETCH) begin o.pcw++; o.src = int'(pc_src); end
      if (rf_we) begin o.rf++; o.wb = int'(wb_sel); end
      if (fp_rf_we) o.fp++;
      if (fcc_we) o.fcc++;
      if (link_we) o.link++;
      if (alu_start) o.start++;
      if (dmem_req) begin o.mem++; if (dmem_we) o.we++; end
      @(negedge clk);
      c++;
    end
    alu_done = 1'b0;
    if (o.cyc < MAXC) n_ret++;
  endtask

  task automatic check_vec(input int i, input obs_t o);
    string p;
    p = $sformatf("v%0d", i);
    chk({p, ".cycles"}, o.cyc, vecs[i].e_cyc);
    chk({p, ".ir_write"}, o.irw, 1);
    chk({p, ".pc_write"}, o.pcw, vecs[i].e_pcw);
    if (vecs[i].e_pcw > 0) chk({p, ".pc_src"}, o.src, vecs[i].e_src);
    chk({p, ".rf_we"}, o.rf, vecs[i].e_rf);
    if (vecs[i].e_rf > 0) chk({p, ".wb_sel"}, o.wb, vecs[i].e_wb);
    chk({p, ".fp_rf_we"}, o.fp, vecs[i].e_fp);
    chk({p, ".fcc_we"}, o.fcc, vecs[i].e_fcc);
    chk({p, ".link_we"}, o.link, vecs[i].e_link);
    chk({p, ".alu_start"}, o.start, vecs[i].e_start);
    chk({p, ".dmem_req"}, o.mem, vecs[i].e_mem);
    chk({p, ".dmem_we"}, o.we, vecs[i].e_we);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  initial begin
    obs_t o;
    int n, bad;
    //                op     aop      flags         js     md  lat cyc pcw src rf wb fp fcc lnk st mem we
    vecs[0]  = mk(6'h00, 4'b0010, 9'b100000000, 2'b00, 0,  0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // add
    vecs[1]  = mk(6'h23, 4'b0010, 9'b110000000, 2'b00, 3,  0, 8, 0, 0, 1, 1, 0, 0, 0, 0, 4, 0); // lw slow
    vecs[2]  = mk(6'h2B, 4'b0010, 9'b001000000, 2'b00, 0,  0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); // sw
    vecs[3]  = mk(6'h04, 4'b0110, 9'b000100001, 2'b00, 0,  0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // beq taken
    vecs[4]  = mk(6'h04, 4'b0110, 9'b000100000, 2'b00, 0,  0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // beq not
    vecs[5]  = mk(6'h02, 4'b0000, 9'b000010000, 2'b00, 0,  0, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0); // j
    vecs[6]  = mk(6'h00, 4'b0000, 9'b000010000, 2'b10, 0,  0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); // jr
    vecs[7]  = mk(6'h03, 4'b0000, 9'b100010000, 2'b00, 0,  0, 2, 1, 2, 1, 2, 0, 0, 1, 0, 0, 0); // jal
    vecs[8]  = mk(6'h00, 4'b0011, 9'b100000000, 2'b00, 0,  2, 6, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0); // mult
    vecs[9]  = mk(6'h00, 4'b0100, 9'b100000000, 2'b00, 0, -1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0); // div, done stuck
    vecs[10] = mk(6'h11, 4'b0000, 9'b100001100, 2'b00, 0,  0, 4, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0); // mfc1
    vecs[11] = mk(6'h11, 4'b0000, 9'b000001010, 2'b00, 0,  0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // mtc1
    vecs[12] = mk(6'h11, 4'b0000, 9'b100001000, 2'b00, 0,  0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // add.s
    vecs[13] = mk(6'h11, 4'b0000, 9'b000001000, 2'b00, 0,  0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); // c.eq.s
    vecs[14] = mk(6'h08, 4'b0011, 9'b100000000, 2'b00, 0,  0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // non-R 0011
    vecs[15] = mk(6'h00, 4'b0101, 9'b100000000, 2'b00, 0,  0, 8, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0); // divu timeout

    // Reset holds every output low even with en and readies high.
    en = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    #12;
    chk("reset.outs", int'(outs), 0);
    chk("reset.cycle_cnt", int'(cycle_cnt), 0);
    chk("reset.instret_cnt", int'(instret_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV - 1; i++) begin
      run_instr(vecs[i], -1, o);
      check_vec(i, o);
    end
    chk("alu_err.before_timeout", int'(alu_err), 0);

    // en low in FETCH: no request, no progress.
    en = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (imem_req || ir_write || state != ST_FETCH) bad++;
      @(negedge clk);
    end
    chk("en_low.hold", bad, 0);

    // en dropped during EXEC of a store: instruction completes, next fetch withheld.
    run_instr(vecs[2], 2, o);
    chk("en_drop.cycles", o.cyc, 4);
    chk("en_drop.dmem_we", o.we, 1);
    #1;
    chk("en_drop.no_req", int'(imem_req), 0);
    @(negedge clk);
    #1;
    chk("en_drop.state", int'(state), int'(ST_FETCH));

`ifdef MC_PERF_CNT_EN
    chk("instret", int'(instret_cnt), n_ret);
`else
    chk("instret_off", int'(instret_cnt), 0);
    chk("cycle_off", int'(cycle_cnt), 0);
`endif

    // alu_done never arrives: single start, four wait cycles, sticky error, still writes back.
    run_instr(vecs[NV-1], -1, o);
    check_vec(NV - 1, o);
    chk("alu_err.set", int'(alu_err), 1);
    run_instr(vecs[0], -1, o);
    chk("alu_err.sticky", int'(alu_err), 1);
    chk("after_err.cycles", o.cyc, 4);

    // Reset asserted while a load waits on dmem_ready.
    {dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump,
     dec_is_float, dec_mfc1, dec_mtc1, branch_cond} = vecs[1].flags;
    dec_opcode = vecs[1].opcode; dec_alu_op = vecs[1].alu_op; dec_jump_src = vecs[1].jsrc;
    en = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    n = 0;
    while (state != ST_MEM && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mem.reach", int'(state), int'(ST_MEM));
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (!dmem_req || dmem_we) bad++;
      @(negedge clk);
    end
    chk("rst_mem.req_held", bad, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mem.outs", int'(outs), 0);
    chk("rst_mem.instret", int'(instret_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mem.first_fetch", int'(imem_req), 1);
    chk("rst_mem.state", int'(state), int'(ST_FETCH));
    chk("rst_mem.cycle_cnt", int'(cycle_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing FSM for the mini-MIPS core.
- Consumes the instruction decoder's control outputs and steps the shared datapath through FETCH / DECODE / EXEC / MEM / WB.
- Drives PC/IR/register-file write enables, memory request/ready handshakes and multi-cycle ALU start/done.
- Sits between the decoder and the datapath/memories; the only source of write enables in the core.

Parameters:
ALU_TIMEOUT, 0, cycles to wait for alu_done before forcing progress and flagging alu_err; 0 = wait forever
LINK_REG, 31, destination register index for jal link write
CNT_W, 32, width of performance counters (optional feature)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low = hold in FETCH with no request issued
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data write (valid with dmem_req)
dmem_ready  in  1  data access complete
dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_is_float, dec_mfc1, dec_mtc1  in  1 each  decoder controls
dec_jump_src  in  2  10 = jr
dec_alu_op  in  4  decoder ALU op
dec_opcode  in  6  decoder opcode
branch_cond  in  1  datapath branch comparison result
alu_start  out  1  multi-cycle ALU start pulse
alu_done  in  1  multi-cycle ALU result ready
ir_write  out  1  latch instruction register
pc_write  out  1  update PC
pc_src  out  2  00 pc+4, 01 branch target, 10 jump target, 11 register (jr)
rf_we  out  1  integer RF write
fp_rf_we  out  1  FP RF write
fcc_we  out  1  FP condition flag write
wb_sel  out  2  00 ALU, 01 memory, 10 pc+4 (link), 11 FP→int move
link_we  out  1  force RF dest = LINK_REG
alu_err  out  1  sticky ALU timeout flag
state  out  3  current state encoding
cycle_cnt, instret_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (async, rst_n low): state = FETCH; every output 0, alu_err cleared; counters 0. Any outstanding request is abandoned.
- FETCH:
  - imem_req = en.
  - On imem_ready: ir_write = 1, pc_write = 1, pc_src = 00 → DECODE.
- DECODE (1 cycle):
  - dec_jump: pc_write = 1, pc_src = 11 if dec_jump_src == 10, else 10.
  - If jal: rf_we = 1, link_we = 1, wb_sel = 10.
  - Jumps → FETCH; all other instructions → EXEC.
- EXEC:
  - Multi-cycle op (dec_opcode == 0 and dec_alu_op ∈ {0011, 0100, 0101}): alu_start pulses on EXEC entry only, then hold until alu_done (earliest the cycle after start).
  - Otherwise EXEC lasts 1 cycle.
  - dec_branch: pc_write = branch_cond, pc_src = 01 → FETCH.
  - mem_read / mem_write → MEM.
  - Otherwise → WB.
- MEM:
  - dmem_req = 1, dmem_we = dec_mem_write; both held stable until dmem_ready.
  - Loads → WB; stores → FETCH.
- WB (1 cycle) → FETCH:
  - rf_we = (dec_reg_write & !dec_is_float) | dec_mfc1.
  - fp_rf_we = (dec_reg_write & dec_is_float & !dec_mfc1) | dec_mtc1.
  - fcc_we = dec_is_float & !dec_reg_write & !dec_mtc1.
  - wb_sel: 01 for loads, 11 for mfc1, else 00.
- Latency with zero-wait memory:
  - j/jal: 2 cycles.
  - Branch: 3 cycles.
  - ALU op or sw: 4 cycles.
  - lw: 5 cycles.
  - Multi-cycle ALU ops: add the alu_done wait.
- Handshake and boundary rules:
  - Requests never deassert before ready.
  - ready arriving in the same cycle as a req assertion completes that cycle.
  - ready seen outside a waiting state is ignored.
  - en low mid-instruction: the current instruction completes; the next fetch is not issued.
  - Timeout: ALU_TIMEOUT > 0 and the wait reaches ALU_TIMEOUT cycles → alu_err = 1 (sticky until reset), and the FSM proceeds as if alu_done.
- Decoder outputs must be stable from DECODE to the end of the instruction (IR-held).

Optional Feature:
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle while en = 1.
  - instret_cnt increments on the final cycle of each instruction.
  - Both wrap modulo 2^CNT_W.
- Undefined: both counter outputs are tied to 0 and no counter logic is synthesized; ports remain present.

Decomposition:
- Package mc_ctrl_pkg:
  - State encodings FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
  - pc_src and wb_sel encodings.
  - Multi-cycle alu_op constants and the jr jump_src constant.
- One sub-module, mc_perf_counters, instantiated only under MC_PERF_CNT_EN.

Test Plan:
- add (opcode 0, funct 100000), imem_ready immediate → states F,D,E,W; rf_we = 1 in cycle 4, wb_sel = 00; instret_cnt = 1.
- lw with dmem_ready delayed 3 cycles → dmem_req held 4 cycles, then WB with rf_we = 1, wb_sel = 01; total 8 cycles.
- beq with branch_cond = 1 then 0 → pc_write = 1, pc_src = 01 in EXEC only for the first; both return to FETCH after 3 cycles.
- jr (dec_jump_src = 10) → pc_src = 11 in DECODE; jal → rf_we = 1, link_we = 1, wb_sel = 10, pc_src = 10.
- mul with ALU_TIMEOUT = 4 and alu_done never asserted → alu_start a single pulse; alu_err = 1 after 4 wait cycles; proceeds to WB.
- rst_n low during MEM wait → all outputs 0 immediately, state = FETCH; the first fetch after release issues imem_req.
